// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the free-running refclk: sequences the PLL reset, retries on
// lock timeout, and releases sys_rst only after lock has been stable for STABLE_CYCLES.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_FILTER   = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // One shared timer serves every state, so it is sized for the largest bound.
    localparam int unsigned MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B = (STABLE_CYCLES > LOSS_FILTER) ? STABLE_CYCLES : LOSS_FILTER;
    localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW    = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] T_RST_END  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] T_TIMEOUT  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_STABLE   = TW'(STABLE_CYCLES);
    localparam logic [TW-1:0] T_LOSS_END = TW'(LOSS_FILTER - 1);

    state_t                 r_state;
    logic [TW-1:0]          r_timer;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pll_rst;
    logic                   r_sys_rst;
    logic                   r_ready;
    logic [CNT_W-1:0]       r_retry;
    logic [CNT_W-1:0]       r_loss;

    state_t                 w_state_nx;
    logic [TW-1:0]          w_timer_nx;
    logic                   w_retry_inc;
    logic                   w_loss_inc;
    logic                   w_lk_s;

    assign w_lk_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = r_timer;
        w_retry_inc = 1'b0;
        w_loss_inc  = 1'b0;
        case (r_state)
            S_RESET_PLL: begin
                if (r_timer >= T_RST_END) begin
                    w_state_nx = S_WAIT_LOCK;
                    w_timer_nx = '0;
                end else begin
                    w_timer_nx = r_timer + TW'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (w_lk_s) begin
                    w_state_nx = S_STABLE;
                    w_timer_nx = TW'(1);
                end else if (r_timer >= T_TIMEOUT) begin
                    w_state_nx  = S_RESET_PLL;
                    w_timer_nx  = '0;
                    w_retry_inc = 1'b1;
                end else begin
                    w_timer_nx = r_timer + TW'(1);
                end
            end
            S_STABLE: begin
                if (!w_lk_s) begin
                    w_state_nx = S_WAIT_LOCK;
                    w_timer_nx = '0;
                end else if (r_timer >= T_STABLE) begin
                    w_state_nx = S_RUN;
                    w_timer_nx = '0;
                end else begin
                    w_timer_nx = r_timer + TW'(1);
                end
            end
            S_RUN: begin
                // In RUN the timer is the consecutive-unlock filter; a counted loss outranks force_relock.
                if (!w_lk_s && (r_timer >= T_LOSS_END)) begin
                    w_state_nx = S_RESET_PLL;
                    w_timer_nx = '0;
                    w_loss_inc = 1'b1;
                end else if (force_relock) begin
                    w_state_nx = S_RESET_PLL;
                    w_timer_nx = '0;
                end else if (!w_lk_s) begin
                    w_timer_nx = r_timer + TW'(1);
                end else begin
                    w_timer_nx = '0;
                end
            end
            default: begin
                w_state_nx = S_RESET_PLL;
                w_timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= S_RESET_PLL;
            r_timer   <= '0;
            r_sync    <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_retry   <= '0;
            r_loss    <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], locked};
            r_state   <= w_state_nx;
            r_timer   <= w_timer_nx;
            r_pll_rst <= (w_state_nx == S_RESET_PLL);
            r_sys_rst <= (w_state_nx != S_RUN);
            r_ready   <= (w_state_nx == S_RUN);
            if (w_retry_inc && (r_retry != '1)) begin
                r_retry <= r_retry + CNT_W'(1);
            end
            if (w_loss_inc && (r_loss != '1)) begin
                r_loss <= r_loss + CNT_W'(1);
            end
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign state_o   = r_state;
    assign retry_cnt = r_retry;
    assign loss_cnt  = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expectations are queued as stimulus is applied
// and popped against measured durations/latencies and output snapshots.
module tb_pll_lock_supervisor;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_TO   = 100;
    localparam int unsigned P_STB  = 8;
    localparam int unsigned P_LOSS = 3;
    localparam int unsigned P_SYNC = 2;

    localparam logic [31:0] ST_RESET  = 32'd0;
    localparam logic [31:0] ST_WAIT   = 32'd1;
    localparam logic [31:0] ST_STABLE = 32'd2;
    localparam logic [31:0] ST_RUN    = 32'd3;

    localparam int C_PLLRST = 0;
    localparam int C_WAIT   = 1;
    localparam int C_NOTRDY = 2;
    localparam int C_RUN    = 3;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       force_relock;

    logic       pll_rst, sys_rst, ready;
    logic [1:0] state_o;
    logic [7:0] retry_cnt, loss_cnt;

    logic       w2_pll_rst, w2_sys_rst, w2_ready;
    logic [1:0] w2_state_o;
    logic [1:0] w2_retry_cnt, w2_loss_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    string       tag_q[$];
    logic [31:0] val_q[$];

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_CYCLES(P_RST), .LOCK_TIMEOUT(P_TO), .STABLE_CYCLES(P_STB),
        .LOSS_FILTER(P_LOSS), .SYNC_STAGES(P_SYNC), .CNT_W(8)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .force_relock(force_relock),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .state_o(state_o),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    // Narrow-counter instance on the same stimulus, used to observe saturation.
    pll_lock_supervisor #(
        .RST_CYCLES(P_RST), .LOCK_TIMEOUT(P_TO), .STABLE_CYCLES(P_STB),
        .LOSS_FILTER(P_LOSS), .SYNC_STAGES(P_SYNC), .CNT_W(2)
    ) dut_w2 (
        .refclk(refclk), .rst(rst), .locked(locked), .force_relock(force_relock),
        .pll_rst(w2_pll_rst), .sys_rst(w2_sys_rst), .ready(w2_ready), .state_o(w2_state_o),
        .retry_cnt(w2_retry_cnt), .loss_cnt(w2_loss_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        if (val_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got %0d expected nothing queued", act);
        end else begin
            check_val(tag_q.pop_front(), act, val_q.pop_front());
        end
    endtask

    function automatic bit cond_hold(input int sel);
        case (sel)
            C_PLLRST: return (pll_rst === 1'b1);
            C_WAIT:   return (32'(state_o) === ST_WAIT);
            C_NOTRDY: return (ready !== 1'b1);
            C_RUN:    return (32'(state_o) === ST_RUN);
            default:  return 1'b0;
        endcase
    endfunction

    // Counts negedge samples (current one included) for which the condition holds.
    task automatic count_while(input int sel, input int unsigned bound, output int unsigned n);
        n = 0;
        while (cond_hold(sel) && (n < bound)) begin
            n++;
            @(negedge refclk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned drops;
        logic        seen;

        rst = 1'b1; locked = 1'b0; force_relock = 1'b0;
        sb_push("rst_state", ST_RESET);
        sb_push("rst_pll_rst", 1);
        sb_push("rst_sys_rst", 1);
        sb_push("rst_ready", 0);
        sb_push("rst_retry", 0);
        sb_push("rst_loss", 0);
        sb_push("rst_w2_loss", 0);
        repeat (3) @(negedge refclk);
        sb_pop(32'(state_o)); sb_pop(32'(pll_rst)); sb_pop(32'(sys_rst)); sb_pop(32'(ready));
        sb_pop(32'(retry_cnt)); sb_pop(32'(loss_cnt)); sb_pop(32'(w2_loss_cnt));

        // Release reset; locked arrives 10 cycles later.
        rst = 1'b0;
        sb_push("t1_pll_rst_len", P_RST);
        sb_push("t1_wait_state", ST_WAIT);
        count_while(C_PLLRST, 1000, n); sb_pop(n);
        repeat (10 - P_RST) @(negedge refclk);
        sb_pop(32'(state_o));
        locked = 1'b1;
        sb_push("t1_lock_lat", P_SYNC + P_STB + 1);
        sb_push("t1_sys_rst", 0);
        sb_push("t1_state", ST_RUN);
        count_while(C_NOTRDY, 1000, n); sb_pop(n);
        sb_pop(32'(sys_rst)); sb_pop(32'(state_o));

        // Two-cycle unlock glitch is filtered out.
        repeat (3) @(negedge refclk);
        locked = 1'b0;
        repeat (2) @(negedge refclk);
        locked = 1'b1;
        sb_push("t4_glitch_drops", 0);
        sb_push("t4_loss0", 0);
        drops = 0;
        repeat (8) begin
            @(negedge refclk);
            if (ready !== 1'b1 || 32'(state_o) !== ST_RUN) drops++;
        end
        sb_pop(drops); sb_pop(32'(loss_cnt));

        // Sustained unlock: third filtered low sample counts as a loss.
        locked = 1'b0;
        sb_push("t4_loss_lat", P_SYNC + P_LOSS);
        sb_push("t4_state", ST_RESET);
        sb_push("t4_sys_rst", 1);
        sb_push("t4_ready", 0);
        sb_push("t4_pll_rst", 1);
        sb_push("t4_loss1", 1);
        count_while(C_RUN, 1000, n); sb_pop(n);
        sb_pop(32'(state_o)); sb_pop(32'(sys_rst)); sb_pop(32'(ready));
        sb_pop(32'(pll_rst)); sb_pop(32'(loss_cnt));

        // Lock never comes: three timeouts, each followed by a reset pulse.
        for (int i = 0; i < 3; i++) begin
            sb_push($sformatf("t2_pll_rst_len%0d", i), P_RST);
            sb_push($sformatf("t2_wait_len%0d", i), P_TO);
        end
        sb_push("t2_pll_rst_len3", P_RST);
        sb_push("t2_retry", 3);
        for (int i = 0; i < 3; i++) begin
            count_while(C_PLLRST, 1000, n); sb_pop(n);
            count_while(C_WAIT, 1000, n); sb_pop(n);
        end
        count_while(C_PLLRST, 1000, n); sb_pop(n);
        sb_pop(32'(retry_cnt));

        // Lock with a one-cycle dropout while STABLE has counted 5.
        locked = 1'b1;
        sb_push("t3_in_stable", ST_STABLE);
        repeat (5) @(negedge refclk);
        sb_pop(32'(state_o));
        locked = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        sb_push("t3_back_to_wait", 1);
        sb_push("t3_relock_lat", P_SYNC + P_STB + 1);
        sb_push("t3_retry", 3);
        n = 0; seen = 1'b0;
        while ((ready !== 1'b1) && (n < 1000)) begin
            if (32'(state_o) === ST_WAIT) seen = 1'b1;
            n++;
            @(negedge refclk);
        end
        sb_pop(32'(seen)); sb_pop(n); sb_pop(32'(retry_cnt));

        // Forced relock from RUN.
        repeat (2) @(negedge refclk);
        force_relock = 1'b1;
        @(negedge refclk);
        force_relock = 1'b0;
        sb_push("t5_state", ST_RESET);
        sb_push("t5_ready", 0);
        sb_push("t5_sys_rst", 1);
        sb_push("t5_pll_rst_len", P_RST);
        sb_push("t5_ready_lat", P_STB + 1);
        sb_push("t5_retry", 3);
        sb_push("t5_loss", 1);
        sb_pop(32'(state_o)); sb_pop(32'(ready)); sb_pop(32'(sys_rst));
        count_while(C_PLLRST, 1000, n); sb_pop(n);
        count_while(C_NOTRDY, 1000, n); sb_pop(n);
        sb_pop(32'(retry_cnt)); sb_pop(32'(loss_cnt));

        // Second loss, relock, then synchronous reset from RUN clears counters.
        locked = 1'b0;
        sb_push("t6_loss_lat", P_SYNC + P_LOSS);
        sb_push("t6_loss2", 2);
        count_while(C_RUN, 1000, n); sb_pop(n);
        sb_pop(32'(loss_cnt));
        locked = 1'b1;
        sb_push("t6_relock_lat", P_RST + 1 + P_STB);
        count_while(C_NOTRDY, 1000, n); sb_pop(n);
        repeat (2) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        sb_push("t6_rst_state", ST_RESET);
        sb_push("t6_rst_ready", 0);
        sb_push("t6_rst_loss", 0);
        sb_push("t6_rst_retry", 0);
        sb_push("t6_rst_w2_loss", 0);
        sb_pop(32'(state_o)); sb_pop(32'(ready)); sb_pop(32'(loss_cnt));
        sb_pop(32'(retry_cnt)); sb_pop(32'(w2_loss_cnt));

        // Five losses: wide counter reaches 5, 2-bit counter holds at 3.
        for (int i = 0; i < 5; i++) begin
            sb_push($sformatf("t6_ready%0d", i), 1);
            sb_push($sformatf("t6_loss_lat%0d", i), P_SYNC + P_LOSS);
        end
        sb_push("t6_loss5", 5);
        sb_push("t6_w2_loss_sat", 3);
        sb_push("t6_w2_retry", 0);
        for (int i = 0; i < 5; i++) begin
            count_while(C_NOTRDY, 1000, n);
            sb_pop(32'(ready));
            locked = 1'b0;
            count_while(C_RUN, 1000, n); sb_pop(n);
            locked = 1'b1;
        end
        sb_pop(32'(loss_cnt)); sb_pop(32'(w2_loss_cnt)); sb_pop(32'(w2_retry_cnt));

        if (val_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending expected 0", val_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
